// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types, constants and match helper for pipeline hazard control
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } ctrl_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when a writing producer targets a real register that a consumer reads
   function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
      return we && (rd != REG_ZERO) && (rd == rs);
   endfunction

endpackage

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - EX operand bypass selection, MEM producer has priority over WB
module forwarding_unit
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] rs1_ex_i,
   input  logic [4:0] rs2_ex_i,
   input  logic [4:0] rd_mem_i,
   input  logic [4:0] rd_wb_i,
   input  logic       we_mem_i,
   input  logic       we_wb_i,
   output logic [1:0] fwd_a_o,
   output logic [1:0] fwd_b_o
);

   // Youngest producer wins: MEM result is newer than WB data
   always_comb begin
      fwd_a_o = FWD_RF;
      fwd_b_o = FWD_RF;
      if (reg_match(we_mem_i, rd_mem_i, rs1_ex_i)) begin
         fwd_a_o = FWD_MEM;
      end else if (reg_match(we_wb_i, rd_wb_i, rs1_ex_i)) begin
         fwd_a_o = FWD_WB;
      end
      if (reg_match(we_mem_i, rd_mem_i, rs2_ex_i)) begin
         fwd_b_o = FWD_MEM;
      end else if (reg_match(we_wb_i, rd_wb_i, rs2_ex_i)) begin
         fwd_b_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush/forward control with muldiv sequencing (FORWARDING_EN enables bypassing)
module hazard_control_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [4:0]       rs1_DECODE,
   input  logic [4:0]       rs2_DECODE,
   input  logic [4:0]       rs1_EXECUTE,
   input  logic [4:0]       rs2_EXECUTE,
   input  logic [4:0]       Write_Register_EXECUTE,
   input  logic [4:0]       Write_Register_MEMORYACCESS,
   input  logic [4:0]       Write_Register_WRITEBACK,
   input  logic             RegWrite_EXECUTE,
   input  logic             RegWrite_MEMORYACCESS,
   input  logic             RegWrite_WRITEBACK,
   input  logic             MemRead_EXECUTE,
   input  logic             muldiv_EXECUTE,
   input  logic             muldiv_done_i,
   input  logic             branch_taken_MEMORYACCESS,
   output logic [1:0]       ForwardA,
   output logic [1:0]       ForwardB,
   output logic             stall_FETCH,
   output logic             stall_DECODE,
   output logic             stall_EXECUTE,
   output logic             bubble_EXECUTE,
   output logic             bubble_MEMORYACCESS,
   output logic             flush_DECODE,
   output logic             flush_EXECUTE,
   output logic             muldiv_start_o,
   output logic             muldiv_abort_o,
   output logic             md_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int TMO_W = $clog2(MD_TIMEOUT + 1);

   ctrl_state_t      state_q, state_d;
   logic [TMO_W-1:0] md_cnt_q, md_cnt_d;
   logic             md_timeout_q, md_timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic raw_hazard;
   logic stall_fe_c, stall_de_c, stall_ex_c, bubble_ex_c, bubble_mem_c;
   logic flush_de_c, flush_ex_c, start_c, abort_c;

`ifdef FORWARDING_EN
   forwarding_unit u_forwarding_unit (
      .rs1_ex_i (rs1_EXECUTE),
      .rs2_ex_i (rs2_EXECUTE),
      .rd_mem_i (Write_Register_MEMORYACCESS),
      .rd_wb_i  (Write_Register_WRITEBACK),
      .we_mem_i (RegWrite_MEMORYACCESS),
      .we_wb_i  (RegWrite_WRITEBACK),
      .fwd_a_o  (ForwardA),
      .fwd_b_o  (ForwardB)
   );

   // With bypassing only a load result is too late for the dependent instruction
   assign raw_hazard = MemRead_EXECUTE &&
                       (reg_match(RegWrite_EXECUTE, Write_Register_EXECUTE, rs1_DECODE) ||
                        reg_match(RegWrite_EXECUTE, Write_Register_EXECUTE, rs2_DECODE));
`else
   logic unused_fwd_inputs;

   assign ForwardA = FWD_RF;
   assign ForwardB = FWD_RF;

   // Without bypassing any EX or MEM producer blocks; WB is covered by register file write-through
   assign raw_hazard = reg_match(RegWrite_EXECUTE, Write_Register_EXECUTE, rs1_DECODE) ||
                       reg_match(RegWrite_EXECUTE, Write_Register_EXECUTE, rs2_DECODE) ||
                       reg_match(RegWrite_MEMORYACCESS, Write_Register_MEMORYACCESS, rs1_DECODE) ||
                       reg_match(RegWrite_MEMORYACCESS, Write_Register_MEMORYACCESS, rs2_DECODE);

   assign unused_fwd_inputs = ^{rs1_EXECUTE, rs2_EXECUTE, Write_Register_WRITEBACK,
                                RegWrite_WRITEBACK, MemRead_EXECUTE};
`endif

   // Next state and control outputs; branch flush outranks muldiv, which outranks data hazards
   always_comb begin
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;
      md_timeout_d = md_timeout_q;
      stall_fe_c   = 1'b0;
      stall_de_c   = 1'b0;
      stall_ex_c   = 1'b0;
      bubble_ex_c  = 1'b0;
      bubble_mem_c = 1'b0;
      flush_de_c   = 1'b0;
      flush_ex_c   = 1'b0;
      start_c      = 1'b0;
      abort_c      = 1'b0;
      if (branch_taken_MEMORYACCESS) begin
         flush_de_c = 1'b1;
         flush_ex_c = 1'b1;
         if (state_q == MD_BUSY) begin
            abort_c = 1'b1;
            state_d = RUN;
         end
      end else if (state_q == MD_BUSY) begin
         if (muldiv_done_i) begin
            state_d = RUN;
         end else begin
            stall_fe_c   = 1'b1;
            stall_de_c   = 1'b1;
            stall_ex_c   = 1'b1;
            bubble_mem_c = 1'b1;
            // md_cnt_q counts completed busy cycles, so this is busy cycle MD_TIMEOUT
            if (md_cnt_q == TMO_W'(MD_TIMEOUT - 1)) begin
               md_timeout_d = 1'b1;
               abort_c      = 1'b1;
               state_d      = RUN;
            end else begin
               md_cnt_d = md_cnt_q + TMO_W'(1);
            end
         end
      end else begin
         if (muldiv_EXECUTE) begin
            start_c  = 1'b1;
            state_d  = MD_BUSY;
            md_cnt_d = '0;
         end
         if (raw_hazard) begin
            stall_fe_c  = 1'b1;
            stall_de_c  = 1'b1;
            bubble_ex_c = 1'b1;
         end
      end
   end

   // Pipeline controls are held inactive while reset is asserted
   always_comb begin
      stall_FETCH         = stall_fe_c   & ~reset_i;
      stall_DECODE        = stall_de_c   & ~reset_i;
      stall_EXECUTE       = stall_ex_c   & ~reset_i;
      bubble_EXECUTE      = bubble_ex_c  & ~reset_i;
      bubble_MEMORYACCESS = bubble_mem_c & ~reset_i;
      flush_DECODE        = flush_de_c   & ~reset_i;
      flush_EXECUTE       = flush_ex_c   & ~reset_i;
      muldiv_start_o      = start_c      & ~reset_i;
      muldiv_abort_o      = abort_c      & ~reset_i;
      md_timeout_o        = md_timeout_q;
      stall_cnt_o         = stall_cnt_q;
   end

   // Saturating count of cycles where decode is held
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_DECODE && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State, timeout counter, sticky error and performance counter
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= RUN;
         md_cnt_q     <= '0;
         md_timeout_q <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         md_cnt_q     <= md_cnt_d;
         md_timeout_q <= md_timeout_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
`timescale 1ns/1ps
module tb_hazard_control_unit;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // ctrl bit order: stall_F stall_D stall_E bubble_E bubble_M flush_D flush_E start abort
   localparam logic [8:0] C_NONE = 9'b000000000;
   localparam logic [8:0] C_LU   = 9'b110100000;
   localparam logic [8:0] C_MDB  = 9'b111010000;
   localparam logic [8:0] C_FL   = 9'b000001100;
   localparam logic [8:0] C_ST   = 9'b000000010;
   localparam logic [8:0] C_AB   = 9'b000000001;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic [4:0]       rs1_DECODE, rs2_DECODE, rs1_EXECUTE, rs2_EXECUTE;
   logic [4:0]       Write_Register_EXECUTE, Write_Register_MEMORYACCESS, Write_Register_WRITEBACK;
   logic             RegWrite_EXECUTE, RegWrite_MEMORYACCESS, RegWrite_WRITEBACK;
   logic             MemRead_EXECUTE, muldiv_EXECUTE, muldiv_done_i, branch_taken_MEMORYACCESS;
   logic [1:0]       ForwardA, ForwardB;
   logic             stall_FETCH, stall_DECODE, stall_EXECUTE, bubble_EXECUTE, bubble_MEMORYACCESS;
   logic             flush_DECODE, flush_EXECUTE, muldiv_start_o, muldiv_abort_o, md_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [8:0]       ctrl;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rdm;
      logic [4:0] rdw;
      logic       wem;
      logic       wew;
      logic [1:0] ea;
      logic [1:0] eb;
   } fwd_vec_t;

   always #5 clk_i = ~clk_i;

   assign ctrl = {stall_FETCH, stall_DECODE, stall_EXECUTE, bubble_EXECUTE, bubble_MEMORYACCESS,
                  flush_DECODE, flush_EXECUTE, muldiv_start_o, muldiv_abort_o};

   hazard_control_unit #(.MD_TIMEOUT(8), .CNT_W(CNT_W)) dut (
      .clk_i                       (clk_i),
      .reset_i                     (reset_i),
      .rs1_DECODE                  (rs1_DECODE),
      .rs2_DECODE                  (rs2_DECODE),
      .rs1_EXECUTE                 (rs1_EXECUTE),
      .rs2_EXECUTE                 (rs2_EXECUTE),
      .Write_Register_EXECUTE      (Write_Register_EXECUTE),
      .Write_Register_MEMORYACCESS (Write_Register_MEMORYACCESS),
      .Write_Register_WRITEBACK    (Write_Register_WRITEBACK),
      .RegWrite_EXECUTE            (RegWrite_EXECUTE),
      .RegWrite_MEMORYACCESS       (RegWrite_MEMORYACCESS),
      .RegWrite_WRITEBACK          (RegWrite_WRITEBACK),
      .MemRead_EXECUTE             (MemRead_EXECUTE),
      .muldiv_EXECUTE              (muldiv_EXECUTE),
      .muldiv_done_i               (muldiv_done_i),
      .branch_taken_MEMORYACCESS   (branch_taken_MEMORYACCESS),
      .ForwardA                    (ForwardA),
      .ForwardB                    (ForwardB),
      .stall_FETCH                 (stall_FETCH),
      .stall_DECODE                (stall_DECODE),
      .stall_EXECUTE               (stall_EXECUTE),
      .bubble_EXECUTE              (bubble_EXECUTE),
      .bubble_MEMORYACCESS         (bubble_MEMORYACCESS),
      .flush_DECODE                (flush_DECODE),
      .flush_EXECUTE               (flush_EXECUTE),
      .muldiv_start_o              (muldiv_start_o),
      .muldiv_abort_o              (muldiv_abort_o),
      .md_timeout_o                (md_timeout_o),
      .stall_cnt_o                 (stall_cnt_o)
   );

   task automatic clear_inputs();
      rs1_DECODE = 5'd0; rs2_DECODE = 5'd0; rs1_EXECUTE = 5'd0; rs2_EXECUTE = 5'd0;
      Write_Register_EXECUTE = 5'd0; Write_Register_MEMORYACCESS = 5'd0; Write_Register_WRITEBACK = 5'd0;
      RegWrite_EXECUTE = 1'b0; RegWrite_MEMORYACCESS = 1'b0; RegWrite_WRITEBACK = 1'b0;
      MemRead_EXECUTE = 1'b0; muldiv_EXECUTE = 1'b0; muldiv_done_i = 1'b0; branch_taken_MEMORYACCESS = 1'b0;
   endtask

   // Advance one cycle; the caller states whether the cycle just finished held decode
   task automatic next(input bit stalled);
      if (stalled && exp_cnt < CNT_MAX) exp_cnt++;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      clear_inputs();
      MemRead_EXECUTE = 1'b1; RegWrite_EXECUTE = 1'b1; Write_Register_EXECUTE = 5'd4; rs1_DECODE = 5'd4;
      muldiv_EXECUTE = 1'b1; branch_taken_MEMORYACCESS = 1'b1;
      RegWrite_MEMORYACCESS = 1'b1; Write_Register_MEMORYACCESS = 5'd9; rs1_EXECUTE = 5'd9;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_NONE); end
      checks++; if (stall_cnt_o !== '0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt_o); end
      checks++; if (md_timeout_o !== 1'b0) begin failures++; $display("FAIL reset_tmo: got %b expected 0", md_timeout_o); end
      checks++; if (ForwardA !== (FWD ? 2'b01 : 2'b00)) begin failures++; $display("FAIL reset_fwd: got %b expected %b", ForwardA, (FWD ? 2'b01 : 2'b00)); end
      clear_inputs();
      reset_i = 1'b0;
      exp_cnt = 0;
      next(0);
      @(negedge clk_i);
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL idle_ctrl: got %b expected %b", ctrl, C_NONE); end
      next(0);
   endtask

   task automatic test_forwarding();
      fwd_vec_t fv [5];
      fv[0] = '{5'd5, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 2'b01, 2'b00};
      fv[1] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00};
      fv[2] = '{5'd6, 5'd9, 5'd9, 5'd6, 1'b1, 1'b1, 2'b10, 2'b01};
      fv[3] = '{5'd4, 5'd4, 5'd4, 5'd4, 1'b0, 1'b1, 2'b10, 2'b10};
      fv[4] = '{5'd3, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 2'b00, 2'b00};
      for (int i = 0; i < 5; i++) begin
         clear_inputs();
         rs1_EXECUTE = fv[i].rs1; rs2_EXECUTE = fv[i].rs2;
         Write_Register_MEMORYACCESS = fv[i].rdm; RegWrite_MEMORYACCESS = fv[i].wem;
         Write_Register_WRITEBACK = fv[i].rdw; RegWrite_WRITEBACK = fv[i].wew;
         @(negedge clk_i);
         checks++; if (ForwardA !== (FWD ? fv[i].ea : 2'b00)) begin failures++; $display("FAIL fwd_a[%0d]: got %b expected %b", i, ForwardA, (FWD ? fv[i].ea : 2'b00)); end
         checks++; if (ForwardB !== (FWD ? fv[i].eb : 2'b00)) begin failures++; $display("FAIL fwd_b[%0d]: got %b expected %b", i, ForwardB, (FWD ? fv[i].eb : 2'b00)); end
         checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL fwd_ctrl[%0d]: got %b expected %b", i, ctrl, C_NONE); end
         next(0);
      end
   endtask

   task automatic test_load_use();
      clear_inputs();
      MemRead_EXECUTE = 1'b1; RegWrite_EXECUTE = 1'b1; Write_Register_EXECUTE = 5'd3; rs2_DECODE = 5'd3;
      @(negedge clk_i);
      checks++; if (ctrl !== C_LU) begin failures++; $display("FAIL lu_stall: got %b expected %b", ctrl, C_LU); end
      next(1);
      // load has moved to MEM behind the bubble
      clear_inputs();
      RegWrite_MEMORYACCESS = 1'b1; Write_Register_MEMORYACCESS = 5'd3; rs2_DECODE = 5'd3;
      @(negedge clk_i);
      checks++; if (ctrl !== (FWD ? C_NONE : C_LU)) begin failures++; $display("FAIL lu_after: got %b expected %b", ctrl, (FWD ? C_NONE : C_LU)); end
      checks++; if (stall_cnt_o !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL lu_cnt: got %0d expected %0d", stall_cnt_o, exp_cnt); end
      next(!FWD);
      // ALU producer in EX and a load targeting x0
      clear_inputs();
      RegWrite_EXECUTE = 1'b1; Write_Register_EXECUTE = 5'd8; rs1_DECODE = 5'd8;
      @(negedge clk_i);
      checks++; if (ctrl !== (FWD ? C_NONE : C_LU)) begin failures++; $display("FAIL alu_ex: got %b expected %b", ctrl, (FWD ? C_NONE : C_LU)); end
      next(!FWD);
      clear_inputs();
      MemRead_EXECUTE = 1'b1; RegWrite_EXECUTE = 1'b1; Write_Register_EXECUTE = 5'd0;
      @(negedge clk_i);
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL lu_x0: got %b expected %b", ctrl, C_NONE); end
      next(0);
   endtask

   task automatic test_raw_mem();
      clear_inputs();
      RegWrite_MEMORYACCESS = 1'b1; Write_Register_MEMORYACCESS = 5'd7; rs1_DECODE = 5'd7; rs1_EXECUTE = 5'd7;
      @(negedge clk_i);
      checks++; if (ctrl !== (FWD ? C_NONE : C_LU)) begin failures++; $display("FAIL raw_mem: got %b expected %b", ctrl, (FWD ? C_NONE : C_LU)); end
      checks++; if (ForwardA !== (FWD ? 2'b01 : 2'b00)) begin failures++; $display("FAIL raw_mem_fwd: got %b expected %b", ForwardA, (FWD ? 2'b01 : 2'b00)); end
      next(!FWD);
      clear_inputs();
      RegWrite_WRITEBACK = 1'b1; Write_Register_WRITEBACK = 5'd7; rs1_DECODE = 5'd7;
      @(negedge clk_i);
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL raw_wb: got %b expected %b", ctrl, C_NONE); end
      next(0);
   endtask

   task automatic test_muldiv();
      clear_inputs();
      muldiv_EXECUTE = 1'b1;
      @(negedge clk_i);
      checks++; if (ctrl !== C_ST) begin failures++; $display("FAIL md_start: got %b expected %b", ctrl, C_ST); end
      next(0);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk_i);
         checks++; if (ctrl !== C_MDB) begin failures++; $display("FAIL md_busy[%0d]: got %b expected %b", c, ctrl, C_MDB); end
         next(1);
      end
      muldiv_done_i = 1'b1;
      @(negedge clk_i);
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL md_done: got %b expected %b", ctrl, C_NONE); end
      next(0);
      clear_inputs();
      @(negedge clk_i);
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL md_run: got %b expected %b", ctrl, C_NONE); end
      checks++; if (stall_cnt_o !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL md_cnt: got %0d expected %0d", stall_cnt_o, exp_cnt); end
      checks++; if (md_timeout_o !== 1'b0) begin failures++; $display("FAIL md_no_tmo: got %b expected 0", md_timeout_o); end
      next(0);
   endtask

   task automatic test_branch_abort();
      clear_inputs();
      muldiv_EXECUTE = 1'b1;
      @(negedge clk_i);
      checks++; if (ctrl !== C_ST) begin failures++; $display("FAIL br_start: got %b expected %b", ctrl, C_ST); end
      next(0);
      @(negedge clk_i);
      checks++; if (ctrl !== C_MDB) begin failures++; $display("FAIL br_busy: got %b expected %b", ctrl, C_MDB); end
      next(1);
      branch_taken_MEMORYACCESS = 1'b1;
      @(negedge clk_i);
      checks++; if (ctrl !== (C_FL | C_AB)) begin failures++; $display("FAIL br_abort: got %b expected %b", ctrl, (C_FL | C_AB)); end
      next(0);
      clear_inputs();
      @(negedge clk_i);
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL br_run: got %b expected %b", ctrl, C_NONE); end
      next(0);
      muldiv_EXECUTE = 1'b1; branch_taken_MEMORYACCESS = 1'b1;
      @(negedge clk_i);
      checks++; if (ctrl !== C_FL) begin failures++; $display("FAIL br_no_start: got %b expected %b", ctrl, C_FL); end
      next(0);
      clear_inputs();
      @(negedge clk_i);
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL br_still_run: got %b expected %b", ctrl, C_NONE); end
      next(0);
      MemRead_EXECUTE = 1'b1; RegWrite_EXECUTE = 1'b1; Write_Register_EXECUTE = 5'd6; rs1_DECODE = 5'd6;
      branch_taken_MEMORYACCESS = 1'b1;
      @(negedge clk_i);
      checks++; if (ctrl !== C_FL) begin failures++; $display("FAIL br_suppress: got %b expected %b", ctrl, C_FL); end
      next(0);
      clear_inputs();
   endtask

   task automatic test_timeout();
      clear_inputs();
      muldiv_EXECUTE = 1'b1;
      @(negedge clk_i);
      checks++; if (ctrl !== C_ST) begin failures++; $display("FAIL tmo_start: got %b expected %b", ctrl, C_ST); end
      next(0);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk_i);
         checks++; if (ctrl !== C_MDB) begin failures++; $display("FAIL tmo_busy[%0d]: got %b expected %b", c, ctrl, C_MDB); end
         checks++; if (md_timeout_o !== 1'b0) begin failures++; $display("FAIL tmo_early[%0d]: got %b expected 0", c, md_timeout_o); end
         next(1);
      end
      @(negedge clk_i);
      checks++; if (ctrl !== (C_MDB | C_AB)) begin failures++; $display("FAIL tmo_abort: got %b expected %b", ctrl, (C_MDB | C_AB)); end
      next(1);
      clear_inputs();
      @(negedge clk_i);
      checks++; if (md_timeout_o !== 1'b1) begin failures++; $display("FAIL tmo_set: got %b expected 1", md_timeout_o); end
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL tmo_run: got %b expected %b", ctrl, C_NONE); end
      next(0);
      next(0);
      @(negedge clk_i);
      checks++; if (md_timeout_o !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got %b expected 1", md_timeout_o); end
      next(0);
   endtask

   task automatic test_saturation();
      clear_inputs();
      MemRead_EXECUTE = 1'b1; RegWrite_EXECUTE = 1'b1; Write_Register_EXECUTE = 5'd2; rs1_DECODE = 5'd2;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         checks++; if (ctrl !== C_LU) begin failures++; $display("FAIL sat_stall[%0d]: got %b expected %b", c, ctrl, C_LU); end
         next(1);
      end
      clear_inputs();
      @(negedge clk_i);
      checks++; if (stall_cnt_o !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL sat_cnt: got %0d expected %0d", stall_cnt_o, exp_cnt); end
      next(0);
   endtask

   task automatic test_reset_busy();
      clear_inputs();
      muldiv_EXECUTE = 1'b1;
      @(negedge clk_i);
      checks++; if (ctrl !== C_ST) begin failures++; $display("FAIL rb_start: got %b expected %b", ctrl, C_ST); end
      next(0);
      @(negedge clk_i);
      checks++; if (ctrl !== C_MDB) begin failures++; $display("FAIL rb_busy: got %b expected %b", ctrl, C_MDB); end
      next(1);
      #2 reset_i = 1'b1;
      #1;
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL rb_ctrl: got %b expected %b", ctrl, C_NONE); end
      checks++; if (stall_cnt_o !== '0) begin failures++; $display("FAIL rb_cnt: got %0d expected 0", stall_cnt_o); end
      checks++; if (md_timeout_o !== 1'b0) begin failures++; $display("FAIL rb_tmo: got %b expected 0", md_timeout_o); end
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      clear_inputs();
      exp_cnt = 0;
      @(negedge clk_i);
      checks++; if (ctrl !== C_NONE) begin failures++; $display("FAIL rb_run: got %b expected %b", ctrl, C_NONE); end
      next(0);
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_raw_mem();
      test_muldiv();
      test_branch_abort();
      test_timeout();
      test_saturation();
      test_reset_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter: MD_TIMEOUT, 64, max cycles the controller waits for muldiv_done_i before flagging an error.
REQ-002 Parameter: CNT_W, 16, width of the stall performance counter.
REQ-003 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The ports SHALL be:
- clk_i  in  1  clock.
- reset_i  in  1  async active-high reset.
- rs1_DECODE, rs2_DECODE  in  5  source registers in ID.
- rs1_EXECUTE, rs2_EXECUTE  in  5  source registers in EX.
- Write_Register_EXECUTE, Write_Register_MEMORYACCESS, Write_Register_WRITEBACK  in  5  destination registers per stage.
- RegWrite_EXECUTE, RegWrite_MEMORYACCESS, RegWrite_WRITEBACK  in  1  register-write enables.
- MemRead_EXECUTE  in  1  load in EX.
- muldiv_EXECUTE  in  1  multi-cycle op in EX.
- muldiv_done_i  in  1  multi-cycle unit result valid.
- branch_taken_MEMORYACCESS  in  1  Branch AND zero in MEM.
- ForwardA, ForwardB  out  2  operand mux selects: 00 = register file, 01 = MEM ALU result, 10 = WB data.
- stall_FETCH, stall_DECODE, stall_EXECUTE  out  1  hold PC / IF-ID / ID-EX.
- bubble_EXECUTE, bubble_MEMORYACCESS  out  1  load NOP controls into ID-EX / EX-MEM.
- flush_DECODE, flush_EXECUTE  out  1  squash IF-ID / ID-EX.
- muldiv_start_o, muldiv_abort_o  out  1  one-cycle pulses to the multi-cycle unit.
- md_timeout_o  out  1  sticky timeout error.
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles.

Function
REQ-005 Forwarding SHALL be combinational: ForwardA=01 if RegWrite_MEMORYACCESS, Write_Register_MEMORYACCESS!=0 and Write_Register_MEMORYACCESS==rs1_EXECUTE; else 10 on the same test against WB; else 00. ForwardB applies the same tests to rs2_EXECUTE. MEM wins over WB.
REQ-006 A load-use hazard SHALL be: MemRead_EXECUTE, RegWrite_EXECUTE, Write_Register_EXECUTE!=0, and Write_Register_EXECUTE equal to rs1_DECODE or rs2_DECODE.
REQ-007 On a load-use hazard in RUN, stall_FETCH, stall_DECODE and bubble_EXECUTE SHALL assert in the same cycle, for exactly one cycle.
REQ-008 FSM states SHALL be RUN and MD_BUSY.
REQ-009 In RUN with muldiv_EXECUTE=1, the controller SHALL pulse muldiv_start_o and enter MD_BUSY next cycle.
REQ-010 In MD_BUSY:
- stall_FETCH, stall_DECODE, stall_EXECUTE and bubble_MEMORYACCESS SHALL assert each cycle.
- On muldiv_done_i, all four SHALL deassert in that same cycle and the FSM SHALL return to RUN.
REQ-011 A cycle counter SHALL increment each cycle in MD_BUSY and clear on entry. At MD_TIMEOUT cycles, md_timeout_o SHALL set (sticky until reset) and the FSM SHALL return to RUN with muldiv_abort_o pulsed.
REQ-012 branch_taken_MEMORYACCESS=1 SHALL assert flush_DECODE and flush_EXECUTE in that cycle and suppress all stall and bubble outputs.
REQ-013 If branch_taken_MEMORYACCESS=1 occurs in MD_BUSY, the controller SHALL pulse muldiv_abort_o and return to RUN.
REQ-014 If branch_taken_MEMORYACCESS=1 coincides with muldiv_EXECUTE=1 in RUN, muldiv_start_o SHALL NOT pulse.
REQ-015 Priority SHALL be: reset > branch flush > MD_BUSY/timeout > load-use/RAW stall.
REQ-016 stall_cnt_o SHALL increment on every cycle with stall_DECODE=1 and saturate at all-ones.

Reset
REQ-017 Reset SHALL asynchronously force:
- FSM to RUN;
- timeout counter and stall_cnt_o to 0;
- md_timeout_o, muldiv_start_o and muldiv_abort_o to 0.
REQ-018 Stall, bubble and flush outputs SHALL be 0 while reset_i=1. Forward outputs SHALL remain combinational.
REQ-019 Reset asserted during MD_BUSY SHALL abandon the operation without pulsing muldiv_abort_o.

Configuration
REQ-020 Macro FORWARDING_EN defined: behaviour as REQ-005 to REQ-007.
REQ-021 Macro FORWARDING_EN undefined:
- ForwardA and ForwardB SHALL be constant 00.
- A RAW stall (stall_FETCH, stall_DECODE, bubble_EXECUTE) SHALL assert whenever an EX or MEM producer has RegWrite=1, rd!=0 and rd equal to rs1_DECODE or rs2_DECODE.
- No WB stall is needed; the register file writes through.

Structure
REQ-022 Package pipeline_ctrl_pkg SHALL hold:
- fwd_sel_t (FWD_RF, FWD_MEM, FWD_WB);
- ctrl_state_t (RUN, MD_BUSY);
- constant REG_ZERO.
REQ-023 Forwarding logic SHALL be a sub-module, forwarding_unit, instantiated only under FORWARDING_EN.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- MEM rd=5 and WB rd=5, both writing, rs1_EXECUTE=5 -> ForwardA=01. MEM rd=0 with WB rd=0 -> 00.
- Load in EX rd=3, rs2_DECODE=3 -> one-cycle stall_FETCH, stall_DECODE and bubble_EXECUTE. stall_cnt_o +1.
- muldiv_EXECUTE=1, muldiv_done_i after 5 cycles -> start pulse, 5 stalled cycles, stalls drop in the done cycle.
- muldiv busy and branch_taken_MEMORYACCESS at cycle 2 -> muldiv_abort_o pulse, flushes assert, state RUN.
- muldiv_done_i never asserted, MD_TIMEOUT=8 -> md_timeout_o=1 after 8 busy cycles, abort pulse.
- FORWARDING_EN undefined, MEM rd=7, rs1_DECODE=7 -> stall for one cycle; ForwardA stays 00.
